// File: rtl/sram_bus_arbiter.sv
// Two-master (inst/data) arbiter for a single SRAM-like bus, one transaction outstanding.
// Data has priority; a saturating starvation counter forces an inst grant after STARVE_LIMIT data wins.
module sram_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [70:0] inst_cmd,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic [70:0] data_cmd,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        bus_req,
    output logic [70:0] bus_cmd,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOCK = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0] state;
    logic       owner;       // 1 = inst, 0 = data
    logic [3:0] starve_cnt;

    logic       any_req;
    logic       inst_wins;
    logic       sel_inst;
    logic       handshake;

    // In WAIT the select falls back to data, so an idle bus_cmd carries data_cmd.
    always_comb begin
        any_req   = inst_req | data_req;
        inst_wins = inst_req & ((starve_cnt == LIMIT) | ~data_req);
        sel_inst  = 1'b0;
        bus_req   = 1'b0;
        case (state)
            IDLE: begin
                sel_inst = inst_wins;
                bus_req  = any_req;
            end
            LOCK: begin
                sel_inst = owner;
                bus_req  = 1'b1;
            end
            default: begin
                sel_inst = 1'b0;
                bus_req  = 1'b0;
            end
        endcase
        if (!resetn) begin
            bus_req = 1'b0;
        end
        handshake = bus_addr_ok & bus_req;
    end

    assign bus_cmd      = sel_inst ? inst_cmd : data_cmd;

    assign inst_addr_ok = handshake & sel_inst;
    assign data_addr_ok = handshake & ~sel_inst;

    assign inst_data_ok = resetn & bus_data_ok & (state == WAIT) & owner;
    assign data_data_ok = resetn & bus_data_ok & (state == WAIT) & ~owner;

    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            owner      <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if (handshake) begin
                if (sel_inst || !inst_req) begin
                    starve_cnt <= '0;
                end else if (starve_cnt != LIMIT) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (handshake) begin
                        owner <= sel_inst;
                        state <= WAIT;
                    end else if (any_req) begin
                        owner <= sel_inst;
                        state <= LOCK;
                    end
                end
                LOCK: begin
                    if (bus_addr_ok) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus_data_ok) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Shares one SRAM-like memory bus between the instruction-fetch port and the data-access port of the pipelined CPU. The block selects one requester per transaction and forwards its command unchanged. It keeps at most one transaction outstanding and routes the response back to the owner. Data accesses have priority. A starvation counter guarantees that instruction fetch makes forward progress. It sits between the pipeline stages' memory interfaces and the single external bus.

## Interface
- STARVE_LIMIT, 4: consecutive data grants won while inst_req is pending before inst is forced to win (1..15).
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- inst_req  in  1  inst master request
- inst_cmd  in  71  {wr[70], size[69:68], wstrb[67:64], addr[63:32], wdata[31:0]}
- inst_addr_ok  out  1  inst request accepted by bus
- inst_data_ok  out  1  inst response valid
- inst_rdata  out  32  read data to inst master
- data_req, data_cmd, data_addr_ok, data_data_ok, data_rdata: same directions and widths as the inst_* ports, for the data master
- bus_req  out  1  request to memory
- bus_cmd  out  71  forwarded command, same packing as inst_cmd
- bus_addr_ok  in  1  memory accepted request
- bus_data_ok  in  1  memory response valid
- bus_rdata  in  32  memory read data

## Operation
- FSM states: IDLE, LOCK, WAIT.
- IDLE:
  - winner = inst if inst_req & (starve_cnt == STARVE_LIMIT | ~data_req); otherwise data if data_req.
  - bus_req = inst_req | data_req; bus_cmd = winner's cmd (combinational, same cycle).
  - If bus_addr_ok: owner <= winner, go to WAIT.
  - Else, if any req: owner <= winner, go to LOCK.
- LOCK:
  - bus_req = 1; bus_cmd = owner's cmd. The owner is frozen, even if the other master raises req.
  - On bus_addr_ok, go to WAIT.
  - Masters must hold req and cmd stable until addr_ok. If the owner drops req, that is a protocol violation and the behaviour is not checked.
- WAIT:
  - bus_req = 0.
  - On bus_data_ok, assert owner's data_ok and go to IDLE.
- x_addr_ok = bus_addr_ok & bus_req & (selected master == x), in IDLE/LOCK only.
- x_data_ok = bus_data_ok & (state == WAIT) & (owner == x).
- inst_rdata = data_rdata = bus_rdata, broadcast. Only the data_ok qualifies it.
- bus_addr_ok while bus_req = 0 is ignored. bus_data_ok outside WAIT is ignored; no data_ok is issued and the state does not change.
- starve_cnt (4 bits), updated on each address handshake:
  - data accepted while inst_req = 1: increment, saturating at STARVE_LIMIT.
  - inst accepted: clear to 0.
  - data accepted with inst_req = 0: clear to 0.
- When bus_cmd is idle (WAIT, or IDLE with no req), it carries data_cmd. The value has no meaning.

## Timing
- Reset (resetn low, async): state = IDLE, owner = data, starve_cnt = 0.
  - bus_req, inst_addr_ok, data_addr_ok, inst_data_ok and data_data_ok are forced to 0 while resetn = 0.
  - Release is synchronous to the next clk edge.
- Zero added latency: a request in IDLE reaches bus_req in the same cycle, and bus_addr_ok returns to the master in the same cycle.
- data_ok and rdata pass through combinationally in the bus_data_ok cycle.
- Back-to-back: the cycle of bus_data_ok returns to IDLE, so the next address handshake can occur at the earliest one cycle later. With a 1-cycle memory, peak throughput is 1 transaction per 2 cycles.
- Simultaneous inst_req and data_req in IDLE: data wins unless starve_cnt == STARVE_LIMIT.
- Reset asserted in LOCK/WAIT: the transaction is dropped. A late bus_data_ok after reset is ignored, per the rule above.

## Test plan
- Single read: data_req with addr 0x1C000040 and wr = 0.
  - In the same cycle bus_req = 1 and bus_cmd = data_cmd. The memory gives addr_ok in cycle 0 and data_ok with 0xDEADBEEF in cycle 2.
  - Required: data_addr_ok in cycle 0; data_data_ok and data_rdata = 0xDEADBEEF in cycle 2. inst_* outputs stay 0.
- Lock: inst_req only, with addr_ok withheld for 3 cycles. data_req rises in cycle 1.
  - Required: bus_cmd = inst_cmd in all 4 cycles; inst_addr_ok in cycle 3; data is served only after inst's data_ok.
- Priority and starvation (STARVE_LIMIT = 4): inst_req and data_req both held high continuously, 1-cycle memory.
  - Required grant order: D, D, D, D, I, D, D, D, D, I, …
- Stray response: bus_data_ok pulsed in IDLE, and bus_addr_ok pulsed with no req.
  - Required: no x_data_ok or x_addr_ok, and the state stays IDLE.
- Async reset in WAIT: drop resetn mid-cycle.
  - Required: bus_req and all *_ok go to 0 immediately, with no clk edge needed.
  - Then release resetn and pulse bus_data_ok: no data_ok is issued, and the next request is granted normally.
- Write forwarding: data write with wstrb 4'b0100, addr 0x00000006, wdata 0x00AB0000.
  - Required: bus_cmd bits match bit-for-bit, and the write completes with data_data_ok.
